// File: rtl/uart8_memoria_arbiter.sv
// uart8_memoria_arbiter: two-master Avalon arbiter for the shared single-port RAM.
// Rev 1.0 - round-robin/fixed grant, tagged two-cycle read return.
`default_nettype none

module uart8_memoria_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic last_grant;
  logic rd_pend;
  logic rd_id;
  logic accept_rd;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && !req1) begin
        grant0 = 1'b1;
      end else if (req1 && !req0) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        if ((FIXED_PRIO != 0) || last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    mem_chipselect = grant0 | grant1;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_clken = 1'b1;

  // Read+write together counts as a write and yields no response.
  assign accept_rd = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
    end else begin
      if (grant0 | grant1) begin
        last_grant <= grant1;
      end
      rd_pend <= accept_rd;
      if (accept_rd) begin
        rd_id <= grant1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= rd_pend & ~rd_id;
      m1_readdatavalid <= rd_pend & rd_id;
      if (rd_pend && !rd_id) begin
        m0_readdata <= mem_readdata;
      end
      if (rd_pend && rd_id) begin
        m1_readdata <= mem_readdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart8_memoria_arbiter.sv
// Bench for uart8_memoria_arbiter: round-robin (dut 0) and fixed-priority (dut 1) instances
// each with a behavioural RAM, checked against a transaction-level reference model.
`default_nettype none

module tb_uart8_memoria_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Master command slots per [dut][master]; a slot holds until accepted.
  logic        rd  [2][2];
  logic        wr  [2][2];
  logic [9:0]  ad  [2][2];
  logic [31:0] wd  [2][2];
  logic [3:0]  be  [2][2];

  logic        wq  [2][2];
  logic        rv  [2][2];
  logic [31:0] rdq [2][2];
  logic        mcs [2];
  logic        mwe [2];
  logic        mck [2];
  logic [9:0]  ma  [2];
  logic [3:0]  mbe [2];
  logic [31:0] mwd [2];

  function automatic logic [31:0] init_word(int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F0000;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [31:0] ram [1024];
    logic [31:0] ram_q;

    initial begin
      ram_q = 32'h0;
      for (int a = 0; a < 1024; a++) ram[a] = init_word(a);
    end

    always @(posedge clk) begin
      if (mcs[d]) begin
        if (mwe[d]) begin
          for (int i = 0; i < 4; i++)
            if (mbe[d][i]) ram[ma[d]][8*i +: 8] <= mwd[d][8*i +: 8];
        end else begin
          ram_q <= ram[ma[d]];
        end
      end
    end

    uart8_memoria_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(d)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(ad[d][0]), .m0_byteenable(be[d][0]), .m0_read(rd[d][0]),
      .m0_write(wr[d][0]), .m0_writedata(wd[d][0]), .m0_waitrequest(wq[d][0]),
      .m0_readdata(rdq[d][0]), .m0_readdatavalid(rv[d][0]),
      .m1_address(ad[d][1]), .m1_byteenable(be[d][1]), .m1_read(rd[d][1]),
      .m1_write(wr[d][1]), .m1_writedata(wd[d][1]), .m1_waitrequest(wq[d][1]),
      .m1_readdata(rdq[d][1]), .m1_readdatavalid(rv[d][1]),
      .mem_address(ma[d]), .mem_byteenable(mbe[d]), .mem_chipselect(mcs[d]),
      .mem_write(mwe[d]), .mem_writedata(mwd[d]), .mem_clken(mck[d]),
      .mem_readdata(ram_q)
    );
  end

  // Reference model state
  typedef struct {
    int          d;
    int          m;
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] shadow [2][1024];
  logic [31:0] lastd  [2][2];
  int          lastg  [2];
  int          acc    [2];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(int d, string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL dut%0d %s observed=%h expected=%h (cycle %0d)", d, tag, obs, expv, cyc);
    end
  endtask

  // Who should own the RAM this cycle, from the arbitration rules.
  function automatic int exp_grant(int d);
    bit r0;
    bit r1;
    r0 = rd[d][0] | wr[d][0];
    r1 = rd[d][1] | wr[d][1];
    if (!reset_n || (!r0 && !r1)) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (d == 1) return 0;
    return (lastg[d] == 0) ? 1 : 0;
  endfunction

  task automatic set_cmd(int d, int m, bit r, bit w, logic [9:0] a, logic [31:0] data, logic [3:0] b);
    rd[d][m] = r;
    wr[d][m] = w;
    ad[d][m] = a;
    wd[d][m] = data;
    be[d][m] = b;
  endtask

  task automatic set_both(int m, bit r, bit w, logic [9:0] a, logic [31:0] data, logic [3:0] b);
    set_cmd(0, m, r, w, a, data, b);
    set_cmd(1, m, r, w, a, data, b);
  endtask

  task automatic step();
    int          g;
    bit          found;
    logic [31:0] ed;
    #4;
    if (!reset_n) exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      acc[d] = -1;
      if (!reset_n) begin
        lastg[d]    = 1;
        lastd[d][0] = 32'h0;
        lastd[d][1] = 32'h0;
      end
      g = exp_grant(d);
      for (int m = 0; m < 2; m++) begin
        chk(d, $sformatf("m%0d_waitrequest", m), 32'(wq[d][m]), 32'(g != m));
        found = 1'b0;
        ed    = lastd[d][m];
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].d == d && exp_q[i].m == m && exp_q[i].due == cyc) begin
            found = 1'b1;
            ed    = exp_q[i].data;
            exp_q.delete(i);
            break;
          end
        end
        chk(d, $sformatf("m%0d_readdatavalid", m), 32'(rv[d][m]), 32'(found));
        chk(d, $sformatf("m%0d_readdata", m), rdq[d][m], ed);
        lastd[d][m] = ed;
      end
      chk(d, "mem_chipselect", 32'(mcs[d]), 32'(g >= 0));
      if (g >= 0) begin
        chk(d, "mem_address", 32'(ma[d]), 32'(ad[d][g]));
        chk(d, "mem_write", 32'(mwe[d]), 32'(wr[d][g]));
        if (wr[d][g]) begin
          chk(d, "mem_writedata", mwd[d], wd[d][g]);
          chk(d, "mem_byteenable", 32'(mbe[d]), 32'(be[d][g]));
          for (int i = 0; i < 4; i++)
            if (be[d][g][i]) shadow[d][ad[d][g]][8*i +: 8] = wd[d][g][8*i +: 8];
        end else begin
          exp_q.push_back('{d: d, m: g, due: cyc + 2, data: shadow[d][ad[d][g]]});
        end
        lastg[d] = g;
        acc[d]   = g;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (acc[d] >= 0) begin
        rd[d][acc[d]] = 1'b0;
        wr[d][acc[d]] = 1'b0;
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      lastg[d] = 1;
      for (int m = 0; m < 2; m++) begin
        set_cmd(d, m, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        lastd[d][m] = 32'h0;
      end
      for (int a = 0; a < 1024; a++) shadow[d][a] = init_word(a);
    end

    // Reset state, with a request pending to show grants are blocked
    set_both(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'hF);
    run(2);
    chk(0, "mem_clken", 32'(mck[0]), 32'h1);
    chk(1, "mem_clken", 32'(mck[1]), 32'h1);
    reset_n = 1'b1;

    // m0 read of 0x005
    run(4);
    chk(0, "t1_m0_data", rdq[0][0], 32'hDEADBEEF);
    chk(1, "t1_m0_data", rdq[1][0], 32'hDEADBEEF);

    // m1 partial write to 0x3FF then read back
    set_both(1, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 4'h3);
    step();
    set_both(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF);
    run(4);
    chk(0, "t2_m1_low", 32'(rdq[0][1][15:0]), 32'h5678);
    chk(1, "t2_m1_low", 32'(rdq[1][1][15:0]), 32'h5678);

    // Continuous contention: both masters reissue reads every cycle
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 2; m++)
          if (!rd[d][m]) set_cmd(d, m, 1'b1, 1'b0, 10'(i + 8 * m), 32'h0, 4'hF);
      step();
    end
    run(6);

    // Reset pulled mid-read
    set_both(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'hF);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(4);

    // Read and write together behave as a write
    set_both(0, 1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 4'hF);
    run(3);
    set_both(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    run(4);
    chk(0, "t6_m0_data", rdq[0][0], 32'hA5A5A5A5);
    chk(1, "t6_m0_data", rdq[1][0], 32'hA5A5A5A5);

    // Randomized mixed traffic with occasional request drops
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int m = 0; m < 2; m++) begin
          if (rd[d][m] || wr[d][m]) begin
            if ($urandom_range(15) == 0) begin
              rd[d][m] = 1'b0;
              wr[d][m] = 1'b0;
            end
          end else if ($urandom_range(3) != 0) begin
            int k;
            k = $urandom_range(4);
            set_cmd(d, m, (k < 2) || (k == 4), (k >= 2),
                    ($urandom_range(7) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(15)),
                    $urandom, 4'($urandom_range(15)));
          end
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        rd[d][m] = 1'b0;
        wr[d][m] = 1'b0;
      end
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart8_memoria_arbiter.md
# uart8_memoria_arbiter

Two-master arbiter that shares the single-port 1024×32 on-chip RAM of the uart8 system between the CPU data master (m0) and the UART receive/transmit buffer engine (m1). It accepts Avalon-style read/write commands from both masters and grants the RAM port to one per cycle, with round-robin or fixed priority. It tags each read and returns `readdata`/`readdatavalid` only to the issuing master. The block sits between the masters and the RAM's `address/byteenable/chipselect/write/writedata/readdata` port.

## Interface
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `FIXED_PRIO`, 0, 0 = round-robin, 1 = m0 always wins a conflict
- `clk`  in  1  single system clock; all logic is rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `mX_address`  in  ADDR_W  word address (X = 0, 1)
- `mX_byteenable`  in  DATA_W/8  byte lanes for writes
- `mX_read`, `mX_write`  in  1  command strobes, held until accepted
- `mX_writedata`  in  DATA_W  write data
- `mX_waitrequest`  out  1  high = command not accepted this cycle
- `mX_readdata`  out  DATA_W  registered read data
- `mX_readdatavalid`  out  1  one-cycle pulse, `mX_readdata` valid
- `mem_address`  out  ADDR_W  to RAM
- `mem_byteenable`  out  DATA_W/8  to RAM
- `mem_chipselect`, `mem_write`  out  1  to RAM
- `mem_writedata`  out  DATA_W  to RAM
- `mem_clken`  out  1  tied 1
- `mem_readdata`  in  DATA_W  RAM output; valid the cycle after the address is presented

## Operation
- Request: `reqX = mX_read | mX_write`.
- Grant is combinational each cycle:
  - Only one master requesting: that master is granted.
  - Both requesting, `FIXED_PRIO=1`: m0 is granted.
  - Both requesting, `FIXED_PRIO=0`: the master not in `last_grant` is granted.
- `last_grant` register (1 bit) updates to the granted id on every accepted command. Reset value 1, so m0 wins the first tie.
- `mX_waitrequest = ~grantX`. It is high whenever master X is not granted, including while idle and during reset.
- RAM port mux:
  - Granted master's address, byteenable and writedata drive the RAM.
  - `mem_chipselect = 1`.
  - `mem_write` = granted master's `mX_write`.
  - With no grant: all `mem_*` outputs are 0 except `mem_clken`.
- `mX_read` and `mX_write` asserted together is treated as a write. No read response is produced.
- Read pipeline, for a read accepted in cycle N:
  - Stage 1 (cycle N+1): `{rd_pend, rd_id}` register.
  - In cycle N+1, `mem_readdata` is captured into the selected `mX_readdata` register.
  - `mX_readdatavalid` pulses in cycle N+2.
- The non-selected master's `readdata` holds its previous value.
- Writes complete in the accepted cycle and produce no response.
- Throughput: one command per cycle, back-to-back, mixed masters and mixed read/write. Pipeline occupancy never stalls acceptance.

## Timing
- Reset values: `last_grant = 1`, `rd_pend = 0`, both `mX_readdatavalid = 0`, both `mX_readdata = 0`.
- While `reset_n = 0`, grants are forced to 0: both waitrequests high and `mem_chipselect = 0`.
- Reset asserted mid-read clears the pipeline. The in-flight read never produces `readdatavalid`.
- Accept-to-readdatavalid latency is exactly 2 cycles. Waitrequest-to-accept is 0 cycles when uncontended.
- Round-robin under continuous contention alternates strictly m0, m1, m0, …. Each master waits at most 1 cycle.
- A master that drops its request while in waitrequest is not granted. No command is latched in that case.
- Address wrap: none. `ADDR_W` bits pass through unmodified.

## Test plan
- Reset release, m0 read addr 0x005 (RAM holds 0xDEADBEEF) → `m0_waitrequest` low in cycle N, `m0_readdatavalid` in N+2, `m0_readdata = 0xDEADBEEF`; m1 outputs unchanged.
- m1 write 0x3FF, data 0x12345678, byteenable 0x3; then m1 read 0x3FF → `readdata = 0x????5678`, where the upper half holds the previous RAM contents.
- Both masters issue reads every cycle for 8 cycles, `FIXED_PRIO=0` → grants m0, m1, m0, … (m0 first after reset). Each master gets 4 readdatavalid pulses with the correct data, in order.
- Same contention with `FIXED_PRIO=1` → m1 waitrequest stays high until m0 drops its request, then m1 is accepted the same cycle.
- m0 read accepted, `reset_n` pulled low at N+1 → no `readdatavalid` on either master; all outputs at reset values.
- m0 asserts read and write together at 0x010, data 0xA5A5A5A5 → RAM written, no `m0_readdatavalid`; a later read returns 0xA5A5A5A5.
